// File: rtl/audio_ctrl_pkg.sv
// audio_ctrl_pkg: shared types and constants for audio_stream_ctrl.
// Optional tone generator is enabled with the TONE_GEN_EN macro.
package audio_ctrl_pkg;

  localparam int SAMPLE_W_DEF = 24;
  localparam int VOL_W_DEF    = 4;

  localparam logic [23:0] SAT_MAX = 24'h7FFFFF;
  localparam logic [23:0] SAT_MIN = 24'h800000;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SCALE,
    WAIT_WR,
    WRITE
  } state_t;

endpackage

// File: rtl/audio_vol_scale.sv
// audio_vol_scale: signed sample * volume/16 plus tone, saturated.
// The tone input is zero when the TONE_GEN_EN macro is not defined.
module audio_vol_scale
  import audio_ctrl_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int VOL_W    = VOL_W_DEF
) (
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic [VOL_W-1:0]    i_volume,
  input  logic [SAMPLE_W-1:0] i_tone,
  output logic [SAMPLE_W-1:0] o_sample
);

  localparam int PW = SAMPLE_W + VOL_W + 1;

  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_shift;
  logic signed [PW:0]   w_sum;
  logic                 w_in_range;

  assign w_prod  = $signed(i_sample) * $signed({1'b0, i_volume});
  // Arithmetic shift floors toward negative infinity.
  assign w_shift = w_prod >>> VOL_W;
  assign w_sum   = (PW+1)'(w_shift) + (PW+1)'($signed(i_tone));

  // In range when all bits above the sample MSB agree with it.
  assign w_in_range = (w_sum[PW:SAMPLE_W-1] == '0) ||
                      (w_sum[PW:SAMPLE_W-1] == '1);

  // Clamp to the signed sample range on overflow.
  always_comb begin
    o_sample = w_sum[SAMPLE_W-1:0];
    if (!w_in_range)
      o_sample = w_sum[PW] ? SAT_MIN : SAT_MAX;
  end

endmodule

// File: rtl/audio_stream_ctrl.sv
// audio_stream_ctrl: frame-by-frame ADC read, volume scale, DAC write.
// Define TONE_GEN_EN to add a square-wave tone to both channels.
module audio_stream_ctrl
  import audio_ctrl_pkg::*;
#(
  parameter int                  SAMPLE_W = SAMPLE_W_DEF,
  parameter int                  VOL_W    = VOL_W_DEF,
  parameter logic [SAMPLE_W-1:0] TONE_AMP = 24'h100000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                en,
  input  logic [VOL_W-1:0]    volume,
  input  logic [15:0]         pitch,
  input  logic                read_ready,
  input  logic                write_ready,
  input  logic [SAMPLE_W-1:0] readdata_left,
  input  logic [SAMPLE_W-1:0] readdata_right,
  output logic                read,
  output logic                write,
  output logic [SAMPLE_W-1:0] writedata_left,
  output logic [SAMPLE_W-1:0] writedata_right,
  output logic [15:0]         frame_count
);

  state_t              r_state;
  state_t              w_next;
  logic [SAMPLE_W-1:0] r_in_l;
  logic [SAMPLE_W-1:0] r_in_r;
  logic                r_read;
  logic                r_write;
  logic [SAMPLE_W-1:0] r_wd_l;
  logic [SAMPLE_W-1:0] r_wd_r;
  logic [15:0]         r_fc;
  logic [SAMPLE_W-1:0] w_tone;
  logic [SAMPLE_W-1:0] w_sc_l;
  logic [SAMPLE_W-1:0] w_sc_r;

`ifdef TONE_GEN_EN
  logic        r_phase_neg;
  logic [15:0] r_tcnt;

  assign w_tone = (pitch == 16'd0) ? '0 :
                  r_phase_neg ? (~TONE_AMP + 1'b1) : TONE_AMP;

  // Toggle tone phase after every `pitch` completed writes.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_phase_neg <= 1'b0;
      r_tcnt      <= '0;
    end else if (r_state == WRITE) begin
      if (pitch == 16'd0) begin
        r_tcnt <= '0;
      end else if ({1'b0, r_tcnt} + 17'd1 >= {1'b0, pitch}) begin
        r_phase_neg <= ~r_phase_neg;
        r_tcnt      <= '0;
      end else begin
        r_tcnt <= r_tcnt + 16'd1;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{pitch, TONE_AMP};
  assign w_tone   = '0;
`endif

  audio_vol_scale #(
    .SAMPLE_W (SAMPLE_W),
    .VOL_W    (VOL_W)
  ) u_scale_l (
    .i_sample (r_in_l),
    .i_volume (volume),
    .i_tone   (w_tone),
    .o_sample (w_sc_l)
  );

  audio_vol_scale #(
    .SAMPLE_W (SAMPLE_W),
    .VOL_W    (VOL_W)
  ) u_scale_r (
    .i_sample (r_in_r),
    .i_volume (volume),
    .i_tone   (w_tone),
    .o_sample (w_sc_r)
  );

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; handshakes only matter in their own state.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (en && read_ready) w_next = READ;
      READ:    w_next = SCALE;
      SCALE:   w_next = WAIT_WR;
      WAIT_WR: if (write_ready) w_next = WRITE;
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_in_l  <= '0;
      r_in_r  <= '0;
      r_wd_l  <= '0;
      r_wd_r  <= '0;
      r_fc    <= '0;
    end else begin
      r_read  <= (w_next == READ);
      r_write <= (w_next == WRITE);
      if (r_state == READ) begin
        r_in_l <= readdata_left;
        r_in_r <= readdata_right;
      end
      if (r_state == SCALE) begin
        r_wd_l <= w_sc_l;
        r_wd_r <= w_sc_r;
      end
      if (w_next == WRITE) r_fc <= r_fc + 16'd1;
    end
  end

  assign read            = r_read;
  assign write           = r_write;
  assign writedata_left  = r_wd_l;
  assign writedata_right = r_wd_r;
  assign frame_count     = r_fc;

endmodule

// File: doc/audio_stream_ctrl.md
Name: audio_stream_ctrl

Overview:
Sequences the audio codec's read/write FIFO handshakes so that one ADC stereo frame is read, scaled by a user volume and written to the DAC. It sits between the top level and the codec interface, and it drives the codec's read, write, writedata_left and writedata_right. It replaces the fixed read=1/write=0 tie-offs with a frame-by-frame controller.

Parameters:
SAMPLE_W, 24, codec sample width in bits (signed two's complement)
VOL_W, 4, volume control width; gain = volume/16
TONE_AMP, 24'h100000, tone generator amplitude (used only with TONE_GEN_EN)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  allow new frames to start
volume  in  VOL_W  gain numerator, 0..15
pitch  in  16  tone half-period in frames; 0 = tone off
read_ready  in  1  codec ADC FIFO holds a frame
write_ready  in  1  codec DAC FIFO has space
readdata_left  in  SAMPLE_W  ADC left sample
readdata_right  in  SAMPLE_W  ADC right sample
read  out  1  pop one ADC frame (one-cycle pulse)
write  out  1  push one DAC frame (one-cycle pulse)
writedata_left  out  SAMPLE_W  DAC left sample
writedata_right  out  SAMPLE_W  DAC right sample
frame_count  out  16  number of frames written, wraps at 0xFFFF -> 0

Behaviour:
- Reset: state=IDLE; read=0, write=0, writedata_*=0, frame_count=0, tone phase=+ and tone counter=0. Reset mid-frame aborts the frame, and no read or write pulse is issued on the following cycle.
- All outputs are registered. read=1 only in READ; write=1 only in WRITE.
- FSM:
  - IDLE: when en & read_ready, go to READ.
  - READ: read=1 for exactly one cycle; latch readdata_left/right into in_l/in_r. Go to SCALE.
  - SCALE: writedata_x = sat((in_x * {1'b0,volume}) >>> 4) (+ tone if enabled); registered. Go to WAIT_WR.
  - WAIT_WR: when write_ready, go to WRITE; otherwise hold. writedata is stable.
  - WRITE: write=1 for one cycle; frame_count+1. Go to IDLE.
- Latency: read_ready=1 in IDLE at cycle N gives read at N+1 and writedata valid at N+3. With write_ready high, write occurs at N+4. Minimum frame period is 5 cycles.
- en is sampled only in IDLE. Deasserting en mid-frame lets the frame complete.
- Arithmetic: signed multiply of SAMPLE_W x (VOL_W+1) bits; arithmetic right shift floors toward negative infinity. volume=0 gives 0. The result is always in range without tone; saturation applies to the tone sum.
- read_ready and write_ready are never acted on in states other than IDLE and WAIT_WR respectively.
- No pulse on read or write is ever longer than one cycle. read and write are never high simultaneously.

Optional Feature:
TONE_GEN_EN
- Defined: a square wave of ±TONE_AMP is added to both channels in SCALE. The sum saturates to 0x7FFFFF / 0x800000.
  - The phase starts at + and toggles after every `pitch` completed WRITEs; the counter counts WRITEs and clears on toggle.
  - pitch=0 adds 0 and holds the counter at 0. A pitch change takes effect at the next counter compare.
- Undefined: no tone logic; the pitch port exists but is ignored; output is the scaled sample only.

Decomposition:
- Package audio_ctrl_pkg contains:
  - the state enum (IDLE, READ, SCALE, WAIT_WR, WRITE);
  - SAMPLE_W and VOL_W defaults;
  - SAT_MAX = 24'h7FFFFF and SAT_MIN = 24'h800000.
- One sub-module, audio_vol_scale: combinational signed multiply, shift and optional tone add with saturation. It is instantiated once per channel.

Test Plan:
- en=1, volume=8, read_ready pulses with L=0x100000, R=0xF00000, write_ready=1 -> read at N+1, write at N+4, L=0x080000, R=0xF80000, frame_count=1.
- volume=15, L=0x7FFFFF, R=0x800000 -> L=0x77FFFF, R=0x880000; volume=0 -> both 0x000000.
- write_ready=0 for 20 cycles after SCALE -> state stays WAIT_WR, write=0, writedata stable, no second read; write_ready=1 -> a single write pulse.
- reset asserted in WAIT_WR -> next cycle read=0, write=0, writedata=0, frame_count=0; the frame is never written.
- en=0 during READ -> the frame completes; no further read while en=0 and read_ready=1.
- TONE_GEN_EN, pitch=2, volume=15, input 0x7FFFFF -> frames 1-2 saturate to 0x7FFFFF, frames 3-4 = 0x67FFFF; 65536 frames -> frame_count wraps to 0.
